pixel_scanout: RTL and testbench

Pixel-generation stage directly downstream of the VGA timing controller. Consumes the controller's `row`, `column` and `displayActive` and drives 8-bit RGB332 colour to the DAC pins. Pixels come from a 640×480 framebuffer in external memory, fetched one line ahead into a ping-pong line buffer over a req/ack memory port. Reports a sticky underrun flag when a line fetch misses its deadline.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/line_buffer_dp.sv | 34 +++
 rtl/pixel_scanout.sv | 172 +++++++++++++++++
 tb/tb_pixel_scanout.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared display constants and types for the VGA pixel pipeline.
//   H_ACTIVE / V_ACTIVE : visible pixels per line / visible lines per frame
//   WORDS_PER_LINE      : 16-bit framebuffer words per visible line
//   rgb332_t            : RGB332 field layout of one framebuffer byte
//   fetchState_t        : line-fetch FSM state encoding
package vga_pkg;

    localparam int unsigned H_ACTIVE       = 640;
    localparam int unsigned V_ACTIVE       = 480;
    localparam int unsigned WORDS_PER_LINE = 320;

    typedef struct packed {
        logic [2:0] red;
        logic [2:0] green;
        logic [1:0] blue;
    } rgb332_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetchState_t;

endpackage

// File: rtl/line_buffer_dp.sv
// Ping-pong line buffer: two banks of WORDS x 16-bit words.
//   clk            : clock
//   wrEn/wrBank/wrIdx/wrData : write port
//   rdBank/rdIdx   : read address
//   rdData         : registered read data (one clk latency)
module line_buffer_dp
    import vga_pkg::*;
#(
    parameter int unsigned WORDS = H_ACTIVE / 2,
    localparam int unsigned IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic             wrBank,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic [15:0]      wrData,
    input  logic             rdBank,
    input  logic [IDX_W-1:0] rdIdx,
    output logic [15:0]      rdData
);

    logic [15:0] ram [2][WORDS];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            ram[wrBank][wrIdx] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        rdData <= ram[rdBank][rdIdx];
    end

endmodule

// File: rtl/pixel_scanout.sv
// Pixel scanout stage: fetches each line one line ahead from external memory
// into a ping-pong buffer and drives RGB332 to the DAC.
//   clk, rst          : clock, async active-high reset
//   clkDiv            : pixel enable (outputs register every clk, so unused)
//   row/column/displayActive : timing controller position and active window
//   memReq/memAddr/memAck/memData : word read port
//   red/green/blue    : pixel colour, zero while blanked
//   underrun          : sticky, set when a line fetch misses its deadline
module pixel_scanout
    import vga_pkg::*;
#(
    parameter int unsigned LINE_WORDS   = WORDS_PER_LINE,
    parameter int unsigned ACTIVE_LINES = V_ACTIVE,
    parameter int unsigned ADDR_W       = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkDiv,
    input  logic [8:0]        row,
    input  logic [9:0]        column,
    input  logic              displayActive,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [15:0]       memData,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              underrun
);

    localparam int unsigned     IDX_W     = $clog2(LINE_WORDS);
    localparam logic [8:0]       LAST_ROW  = 9'(ACTIVE_LINES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_WORDS);

    fetchState_t       state, stateNext;
    logic              startPending;
    logic              daD;
    logic              col0D;
    logic [ADDR_W-1:0] lineBase;
    logic [IDX_W-1:0]  wordIdx;
    logic              fetchBank;
    logic [1:0]        bankValid;
    logic              riseEdge, fallEdge;
    logic              trigWrap, trigNext, trigAny;
    logic              startFetch, wordAck, lastAck;
    logic [15:0]       rdData;
    logic [7:0]        pixByte;
    rgb332_t           pix;
    logic              unusedClkDiv;

    assign unusedClkDiv = clkDiv;

    always_comb begin
        riseEdge = displayActive & ~daD;
        fallEdge = ~displayActive & daD;
        // startPending covers the first clk after reset release
        trigWrap = startPending | (fallEdge & (row == LAST_ROW));
        trigNext = riseEdge & (row < LAST_ROW);
        trigAny  = trigWrap | trigNext;
        wordAck  = (state == REQ) & memAck;
        lastAck  = wordAck & (wordIdx == LAST_IDX);
    end

    always_comb begin
        stateNext  = state;
        startFetch = 1'b0;
        case (state)
            IDLE: begin
                if (trigAny) begin
                    stateNext  = REQ;
                    startFetch = 1'b1;
                end
            end
            REQ: begin
                if (lastAck) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign memReq = (state == REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            startPending <= 1'b1;
            daD          <= 1'b0;
            col0D        <= 1'b0;
            lineBase     <= '0;
            memAddr      <= '0;
            wordIdx      <= '0;
            fetchBank    <= 1'b0;
            bankValid    <= '0;
            underrun     <= 1'b0;
        end else begin
            startPending <= 1'b0;
            daD          <= displayActive;
            col0D        <= column[0];

            // Base tracks every trigger, even ignored ones, so it stays in step with row
            if (trigWrap) begin
                lineBase <= '0;
            end else if (trigNext) begin
                lineBase <= lineBase + LINE_STEP;
            end

            if (startFetch) begin
                memAddr   <= trigWrap ? '0 : lineBase + LINE_STEP;
                wordIdx   <= '0;
                fetchBank <= trigWrap ? 1'b0 : ~row[0];
                bankValid[trigWrap ? 1'b0 : ~row[0]] <= 1'b0;
            end else if (wordAck) begin
                memAddr <= memAddr + ADDR_W'(1);
                wordIdx <= wordIdx + IDX_W'(1);
                if (lastAck) begin
                    bankValid[fetchBank] <= 1'b1;
                end
            end

            // Missed deadline: trigger while busy, or line shown before its fetch finished
            if ((trigAny && state == REQ) || (riseEdge && !bankValid[row[0]])) begin
                underrun <= 1'b1;
            end
        end
    end

    line_buffer_dp #(
        .WORDS(LINE_WORDS)
    ) u_lineBuffer (
        .clk    (clk),
        .wrEn   (wordAck),
        .wrBank (fetchBank),
        .wrIdx  (wordIdx),
        .wrData (memData),
        .rdBank (row[0]),
        .rdIdx  (IDX_W'(column[9:1])),
        .rdData (rdData)
    );

    always_comb begin
        pixByte = col0D ? rdData[15:8] : rdData[7:0];
        pix     = rgb332_t'(pixByte);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (daD) begin
            red   <= pix.red;
            green <= pix.green;
            blue  <= pix.blue;
        end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end
    end

endmodule

// File: tb/tb_pixel_scanout.sv
// Directed bench for pixel_scanout with a behavioural memory that returns
// word n of line L as {L[7:0]^tag, n[7:0]} after ackDelay idle clks.
module tb_pixel_scanout;

    localparam int unsigned LW = 320;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clkDiv = 1'b0;
    logic [8:0]  row = '0;
    logic [9:0]  column = '0;
    logic        displayActive = 1'b0;
    logic        memReq;
    logic [17:0] memAddr;
    logic        memAck = 1'b0;
    logic [15:0] memData = '0;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    int          ackDelay = 0;
    int          waitCnt = 0;
    int          ackCount = 0;
    int          seqBad = 0;
    logic [17:0] firstAddr = '0;
    logic [17:0] lastAddr = '0;
    logic [7:0]  tag = '0;

    pixel_scanout #(
        .LINE_WORDS   (320),
        .ACTIVE_LINES (480),
        .ADDR_W       (18)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clkDiv        (clkDiv),
        .row           (row),
        .column        (column),
        .displayActive (displayActive),
        .memReq        (memReq),
        .memAddr       (memAddr),
        .memAck        (memAck),
        .memData       (memData),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            clkDiv = ~clkDiv;
        end
    end

    // Memory model: acts on the falling edge, ack and data valid for one clk
    initial begin
        forever begin
            @(negedge clk);
            if (memReq && waitCnt >= ackDelay) begin
                memAck  = 1'b1;
                memData = {8'(memAddr / LW) ^ tag, 8'(memAddr % LW)};
                if (ackCount > 0 && memAddr != lastAddr + 18'd1) seqBad++;
                if (ackCount == 0) firstAddr = memAddr;
                lastAddr = memAddr;
                ackCount++;
                waitCnt = 0;
            end else begin
                memAck = 1'b0;
                if (memReq) waitCnt++;
                else waitCnt = 0;
            end
        end
    end

    task automatic clearLog();
        ackCount  = 0;
        seqBad    = 0;
        firstAddr = '0;
        lastAddr  = '0;
    endtask

    task automatic drivePix(input logic [8:0] r, input logic [9:0] c, input logic da);
        @(negedge clk);
        row = r;
        column = c;
        displayActive = da;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic runLine(input logic [8:0] r);
        @(negedge clk);
        row = r;
        column = '0;
        displayActive = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        displayActive = 1'b0;
        repeat (400) @(posedge clk);
        #1;
    endtask

    task automatic blankWait();
        @(negedge clk);
        displayActive = 1'b0;
        repeat (400) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq: got %b expected 0", memReq); end
        checks++; if (memAddr !== 18'd0) begin errors++; $display("FAIL reset_memAddr: got %0d expected 0", memAddr); end
        checks++; if ({red, green, blue} !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %h expected 00", {red, green, blue}); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        clearLog();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL start_memReq: got %b expected 1", memReq); end
        checks++; if (memAddr !== 18'd0) begin errors++; $display("FAIL start_memAddr: got %0d expected 0", memAddr); end
        repeat (400) @(posedge clk);
        #1;
        checks++; if (ackCount != 320) begin errors++; $display("FAIL reset_fetch_count: got %0d expected 320", ackCount); end
        checks++; if (firstAddr !== 18'd0) begin errors++; $display("FAIL reset_fetch_first: got %0d expected 0", firstAddr); end
        checks++; if (lastAddr !== 18'd319) begin errors++; $display("FAIL reset_fetch_last: got %0d expected 319", lastAddr); end
        checks++; if (seqBad != 0) begin errors++; $display("FAIL reset_fetch_seq: got %0d gaps expected 0", seqBad); end
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_fetch_done: got %b expected 0", memReq); end
    endtask

    task automatic test_steady();
        drivePix(9'd0, 10'd4, 1'b1);
        checks++; if ({red, green, blue} !== 8'h02) begin errors++; $display("FAIL line0_word2_lo: got %h expected 02", {red, green, blue}); end
        blankWait();
        for (int r = 1; r <= 4; r++) runLine(9'(r));
        drivePix(9'd5, 10'd323, 1'b1);
        checks++; if ({red, green, blue} !== 8'h05) begin errors++; $display("FAIL line5_word161_hi: got %h expected 05", {red, green, blue}); end
        @(negedge clk);
        column = 10'd214;
        @(posedge clk);
        #1;
        checks++; if ({red, green, blue} !== 8'h05) begin errors++; $display("FAIL latency_1clk: got %h expected 05", {red, green, blue}); end
        @(posedge clk);
        #1;
        checks++; if ({red, green, blue} !== 8'h6B) begin errors++; $display("FAIL line5_word107_lo: got %h expected 6b", {red, green, blue}); end
        checks++; if (red !== 3'd3 || green !== 3'd2 || blue !== 2'd3) begin errors++; $display("FAIL rgb_fields: got %0d/%0d/%0d expected 3/2/3", red, green, blue); end
        drivePix(9'd5, 10'd3, 1'b1);
        checks++; if ({red, green, blue} !== 8'h05) begin errors++; $display("FAIL line5_word1_hi: got %h expected 05", {red, green, blue}); end
        drivePix(9'd5, 10'd323, 1'b0);
        checks++; if ({red, green, blue} !== 8'h00) begin errors++; $display("FAIL blanking: got %h expected 00", {red, green, blue}); end
        blankWait();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL steady_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_line_ahead();
        for (int r = 6; r <= 9; r++) runLine(9'(r));
        clearLog();
        runLine(9'd10);
        checks++; if (firstAddr !== 18'd3520) begin errors++; $display("FAIL ahead_first: got %0d expected 3520", firstAddr); end
        checks++; if (lastAddr !== 18'd3839) begin errors++; $display("FAIL ahead_last: got %0d expected 3839", lastAddr); end
        checks++; if (ackCount != 320 || seqBad != 0) begin errors++; $display("FAIL ahead_count: got %0d acks %0d gaps expected 320 0", ackCount, seqBad); end
        drivePix(9'd11, 10'd14, 1'b1);
        checks++; if ({red, green, blue} !== 8'h07) begin errors++; $display("FAIL bank1_word7_lo: got %h expected 07", {red, green, blue}); end
        drivePix(9'd11, 10'd15, 1'b1);
        checks++; if ({red, green, blue} !== 8'h0B) begin errors++; $display("FAIL bank1_word7_hi: got %h expected 0b", {red, green, blue}); end
        blankWait();
    endtask

    task automatic test_frame_wrap();
        drivePix(9'd479, 10'd0, 1'b1);
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL last_row_no_fetch: got %b expected 0", memReq); end
        tag = 8'h5A;
        clearLog();
        drivePix(9'd479, 10'd0, 1'b0);
        repeat (400) @(posedge clk);
        #1;
        checks++; if (firstAddr !== 18'd0 || lastAddr !== 18'd319) begin errors++; $display("FAIL wrap_addr: got %0d..%0d expected 0..319", firstAddr, lastAddr); end
        checks++; if (ackCount != 320) begin errors++; $display("FAIL wrap_count: got %0d expected 320", ackCount); end
        clearLog();
        drivePix(9'd0, 10'd1, 1'b1);
        checks++; if ({red, green, blue} !== 8'h5A) begin errors++; $display("FAIL wrap_new_data: got %h expected 5a", {red, green, blue}); end
        blankWait();
        checks++; if (firstAddr !== 18'd320) begin errors++; $display("FAIL wrap_line1_base: got %0d expected 320", firstAddr); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL wrap_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_underrun();
        ackDelay = 20;
        drivePix(9'd1, 10'd0, 1'b1);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL slow_before: got %b expected 0", underrun); end
        @(negedge clk);
        displayActive = 1'b0;
        repeat (100) @(posedge clk);
        drivePix(9'd2, 10'd0, 1'b1);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL slow_line_start: got %b expected 1", underrun); end
        ackDelay = 0;
        blankWait();
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL slow_fetch_done: got %b expected 0", memReq); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", underrun); end
    endtask

    task automatic test_reset_mid_fetch();
        tag = 8'h00;
        rst = 1'b1;
        #1;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_clears_underrun: got %b expected 0", underrun); end
        clearLog();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 500 && ackCount < 100; i++) @(posedge clk);
        #1;
        checks++; if (ackCount != 100) begin errors++; $display("FAIL mid_ack_wait: got %0d expected 100", ackCount); end
        checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", memReq); end
        rst = 1'b1;
        #1;
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL mid_rst_memReq: got %b expected 0", memReq); end
        checks++; if (memAddr !== 18'd0) begin errors++; $display("FAIL mid_rst_memAddr: got %0d expected 0", memAddr); end
        repeat (2) @(posedge clk);
        #1;
        clearLog();
        @(negedge clk);
        rst = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        checks++; if (firstAddr !== 18'd0 || lastAddr !== 18'd319) begin errors++; $display("FAIL restart_addr: got %0d..%0d expected 0..319", firstAddr, lastAddr); end
        checks++; if (ackCount != 320 || seqBad != 0) begin errors++; $display("FAIL restart_count: got %0d acks %0d gaps expected 320 0", ackCount, seqBad); end
    endtask

    task automatic test_simultaneous();
        clearLog();
        @(negedge clk);
        row = 9'd20;
        column = '0;
        displayActive = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (memReq !== 1'b1 || underrun !== 1'b0) begin errors++; $display("FAIL coincide_start: got req %b ur %b expected 1 0", memReq, underrun); end
        repeat (10) @(posedge clk);
        @(negedge clk);
        displayActive = 1'b0;
        repeat (309) @(posedge clk);
        @(negedge clk);
        row = 9'd21;
        displayActive = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL coincide_underrun: got %b expected 1", underrun); end
        checks++; if (ackCount != 320) begin errors++; $display("FAIL coincide_complete: got %0d expected 320", ackCount); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (memReq !== 1'b0 || ackCount != 320) begin errors++; $display("FAIL coincide_dropped: got req %b acks %0d expected 0 320", memReq, ackCount); end
        blankWait();
    endtask

    initial begin
        test_reset();
        test_steady();
        test_line_ahead();
        test_frame_wrap();
        test_underrun();
        test_reset_mid_fetch();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
